// File: rtl/absorb_sequencer.sv
// Front end for padding_generator: forwards message words, fills the rate block with pad words,
// and sequences one Keccak-f run per block. Optional macro ABSORB_MODE_SEL_EN adds mode_sel (21-word blocks).
//  state       | meaning
//  S_IDLE      | waiting for start
//  S_ABSORB    | forwarding message words from din
//  S_PAD       | emitting all-pad words until the block is full
//  S_WAIT_PERM | block handed off, waiting for perm_done
module absorb_sequencer #(
   parameter int RATE_WORDS = 17,
   localparam int W = 64,
   localparam int WBW = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
`ifdef ABSORB_MODE_SEL_EN
   input  logic           mode_sel,
`endif
   input  logic [W-1:0]   din,
   input  logic           din_valid,
   input  logic           din_last,
   input  logic [WBW:0]   din_bytes,
   output logic           din_ready,
   output logic [W-1:0]   data_out,
   output logic [WBW:0]   remaining_valid_bytes,
   output logic           padding_enable,
   output logic           last_word_in_block,
   output logic           padding_reset,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           perm_start,
   input  logic           perm_done,
   output logic           absorb_done
);

   typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PAD, S_WAIT_PERM} state_t;

   state_t       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic         final_q, final_d;
   logic         pend_q, pend_d;
   logic [4:0]   blk_last;
   logic [WBW:0] bytes_eff;
   logic         short_last;
   logic         at_end;
   logic         xfer;

`ifdef ABSORB_MODE_SEL_EN
   logic [4:0] len_q, len_d;

   assign len_d = (state_q == S_IDLE && start) ? (mode_sel ? 5'd21 : 5'(RATE_WORDS)) : len_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) len_q <= 5'(RATE_WORDS);
      else     len_q <= len_d;
   end

   assign blk_last = len_q - 5'd1;
`else
   assign blk_last = 5'(RATE_WORDS - 1);
`endif

   // Over-range byte counts saturate at a full word.
   assign bytes_eff  = (din_bytes > 4'd8) ? 4'd8 : din_bytes;
   assign short_last = din_last && (bytes_eff != 4'd8);
   assign at_end     = (cnt_q == blk_last);

   always_comb begin
      xfer = 1'b0;
      case (state_q)
         S_ABSORB: xfer = din_valid & out_ready;
         S_PAD:    xfer = out_ready;
         default:  xfer = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         final_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         final_q <= final_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      final_d = final_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ABSORB;
               cnt_d   = '0;
               final_d = 1'b0;
               pend_d  = 1'b0;
            end
         end
         S_ABSORB: begin
            if (xfer) begin
               if (at_end) begin
                  cnt_d   = '0;
                  state_d = S_WAIT_PERM;
                  // A full final word at the block end still owes a whole pad block.
                  if (din_last) begin
                     if (short_last) final_d = 1'b1;
                     else            pend_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 5'd1;
                  if (din_last) begin
                     final_d = 1'b1;
                     state_d = S_PAD;
                  end
               end
            end
         end
         S_PAD: begin
            if (xfer) begin
               final_d = 1'b1;
               if (at_end) begin
                  cnt_d   = '0;
                  state_d = S_WAIT_PERM;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         S_WAIT_PERM: begin
            if (perm_done) begin
               if (pend_q) begin
                  state_d = S_PAD;
                  pend_d  = 1'b0;
                  final_d = 1'b1;
               end else if (final_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ABSORB;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      data_out              = '0;
      remaining_valid_bytes = '0;
      padding_enable        = 1'b0;
      last_word_in_block    = 1'b0;
      out_valid             = 1'b0;
      din_ready             = 1'b0;
      case (state_q)
         S_ABSORB: begin
            data_out           = din;
            out_valid          = din_valid;
            din_ready          = out_ready;
            last_word_in_block = at_end;
            if (short_last) begin
               padding_enable        = 1'b1;
               remaining_valid_bytes = bytes_eff;
            end else begin
               remaining_valid_bytes = 4'd8;
            end
         end
         S_PAD: begin
            out_valid          = 1'b1;
            padding_enable     = 1'b1;
            last_word_in_block = at_end;
         end
         default: ;
      endcase
   end

   assign perm_start    = xfer & at_end;
   assign absorb_done   = (state_q == S_WAIT_PERM) && perm_done && final_q && !pend_q;
   assign padding_reset = ((state_q == S_IDLE) && start) || absorb_done;

endmodule

// File: tb/tb_absorb_sequencer.sv
// Self-checking bench for absorb_sequencer: table of messages plus random messages checked
// against a word-stream model derived from message length and final byte count.
`timescale 1ns/1ps
module tb_absorb_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] din;
   logic        din_valid;
   logic        din_last;
   logic [3:0]  din_bytes;
   logic        din_ready;
   logic [63:0] data_out;
   logic [3:0]  remaining_valid_bytes;
   logic        padding_enable;
   logic        last_word_in_block;
   logic        padding_reset;
   logic        out_valid;
   logic        out_ready;
   logic        perm_start;
   logic        perm_done;
   logic        absorb_done;
`ifdef ABSORB_MODE_SEL_EN
   logic        mode_sel;
`endif

   absorb_sequencer #(.RATE_WORDS(17)) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef ABSORB_MODE_SEL_EN
      .mode_sel(mode_sel),
`endif
      .din(din), .din_valid(din_valid), .din_last(din_last), .din_bytes(din_bytes),
      .din_ready(din_ready), .data_out(data_out),
      .remaining_valid_bytes(remaining_valid_bytes), .padding_enable(padding_enable),
      .last_word_in_block(last_word_in_block), .padding_reset(padding_reset),
      .out_valid(out_valid), .out_ready(out_ready), .perm_start(perm_start),
      .perm_done(perm_done), .absorb_done(absorb_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  rvb;
      logic        pe;
      logic        lw;
   } word_t;

   typedef struct {
      int n; int b; int vmode; int rmode; int perms; int words;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   int          blk_len = 17;
   word_t       exp_q[$];
   logic [63:0] msg[$];
   vec_t        tbl[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int model_total(input int n, input int b, input int len);
      int be = (b > 8) ? 8 : b;
      if (be < 8) return ((n + len - 1) / len) * len;
      return (n / len + 1) * len;
   endfunction

   task automatic build_model(input int n, input int b, input int len);
      int be = (b > 8) ? 8 : b;
      int total = model_total(n, b, len);
      word_t w;
      msg.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) msg.push_back({$urandom, $urandom});
      for (int i = 0; i < total; i++) begin
         if (i < n) begin
            w.data = msg[i];
            if (i == n - 1 && be < 8) begin w.pe = 1'b1; w.rvb = 4'(be); end
            else                      begin w.pe = 1'b0; w.rvb = 4'd8;   end
         end else begin
            w.data = '0; w.pe = 1'b1; w.rvb = 4'd0;
         end
         w.lw = ((i % len) == len - 1);
         exp_q.push_back(w);
      end
   endtask

   task automatic quiet_inputs();
      start = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0; din_bytes = '0;
      out_ready = 1'b0; perm_done = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ov"}, out_valid, 1'b0);
      check({tag, "_dr"}, din_ready, 1'b0);
      check({tag, "_do"}, data_out, 64'h0);
      check({tag, "_rvb"}, remaining_valid_bytes, 4'd0);
      check({tag, "_pe"}, padding_enable, 1'b0);
      check({tag, "_lw"}, last_word_in_block, 1'b0);
      check({tag, "_ps"}, perm_start, 1'b0);
      check({tag, "_pr"}, padding_reset, 1'b0);
      check({tag, "_ad"}, absorb_done, 1'b0);
   endtask

   // Runs one message from start to absorb_done; entered and left at posedge+1.
   task automatic run_msg(input int n, input int b, input int vmode, input int rmode,
                          input int exp_perms, input int exp_words);
      int  src = 0, perms = 0, dones = 0, cd = 0, cyc = 0, words = 0;
      bit  waitp = 0, done = 0;
      word_t w;
      build_model(n, b, blk_len);
      quiet_inputs();
      start = 1'b1;
      @(negedge clk);
      check("pad_reset_at_start", padding_reset, 1'b1);
      check("idle_no_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      while (!done && cyc < 3000) begin
         din_valid = (src < n) && (vmode == 0 || $urandom_range(0, 2) != 0);
         din       = (src < n) ? msg[src] : {$urandom, $urandom};
         din_last  = (src == n - 1);
         din_bytes = (src == n - 1) ? 4'(b) : 4'($urandom_range(0, 15));
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = ($urandom_range(0, 1) == 1);
         endcase
         perm_done = 1'b0;
         if (waitp) begin
            if (cd == 0) perm_done = 1'b1;
            else cd--;
         end else if ($urandom_range(0, 9) == 0) begin
            perm_done = 1'b1;
         end
         start = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         if (waitp) check("no_valid_in_wait", out_valid, 1'b0);
         if (out_valid && out_ready) begin
            words++;
            if (exp_q.size() == 0) begin
               check("extra_word", 1'b1, 1'b0);
            end else begin
               w = exp_q.pop_front();
               check("data_out", data_out, w.data);
               check("rvb", remaining_valid_bytes, w.rvb);
               check("pad_en", padding_enable, w.pe);
               check("last_in_blk", last_word_in_block, w.lw);
            end
         end
         if (din_valid && din_ready) src++;
         if (waitp && perm_done) waitp = 0;
         if (perm_start) begin
            perms++;
            waitp = 1;
            cd = $urandom_range(0, 3);
         end
         check("pad_reset_only_at_done", padding_reset, absorb_done);
         if (absorb_done) begin
            dones++;
            done = 1;
            check("done_with_perm_done", perm_done, 1'b1);
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("finished_in_budget", done, 1'b1);
      check("perm_starts", perms, exp_perms);
      check("words_out", words, exp_words);
      check("model_drained", exp_q.size(), 0);
      check("src_consumed", src, n);
      quiet_inputs();
      din_valid = 1'b1; out_ready = 1'b1; din = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      check("idle_after_done_ov", out_valid, 1'b0);
      check("idle_after_done_dr", din_ready, 1'b0);
      @(posedge clk); #1;
      quiet_inputs();
   endtask

   task automatic reset_mid_absorb();
      quiet_inputs();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din_valid = 1'b1; out_ready = 1'b1; din = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      din = 64'h0123_4567_89AB_CDEF;
      #1;
      check("mid_ov_before_rst", out_valid, 1'b1);
      check("mid_data_before_rst", data_out, 64'h0123_4567_89AB_CDEF);
      #1 rst = 1'b1;
      #1;
      check_all_zero("rst_async");
      @(negedge clk);
      check_all_zero("rst_next");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_idle_ov", out_valid, 1'b0);
         check("post_rst_no_done", absorb_done, 1'b0);
         @(posedge clk); #1;
      end
      quiet_inputs();
   endtask

   initial begin
      int n, b, t;
      tbl[0] = '{n: 3,  b: 5,  vmode: 0, rmode: 0, perms: 1, words: 17};
      tbl[1] = '{n: 17, b: 8,  vmode: 0, rmode: 0, perms: 2, words: 34};
      tbl[2] = '{n: 17, b: 3,  vmode: 0, rmode: 0, perms: 1, words: 17};
      tbl[3] = '{n: 1,  b: 0,  vmode: 0, rmode: 0, perms: 1, words: 17};
      tbl[4] = '{n: 16, b: 8,  vmode: 0, rmode: 1, perms: 1, words: 17};
      tbl[5] = '{n: 34, b: 8,  vmode: 1, rmode: 2, perms: 3, words: 51};
      tbl[6] = '{n: 20, b: 12, vmode: 0, rmode: 1, perms: 2, words: 34};
      tbl[7] = '{n: 18, b: 2,  vmode: 1, rmode: 0, perms: 2, words: 34};
      tbl[8] = '{n: 5,  b: 4,  vmode: 0, rmode: 1, perms: 1, words: 17};
      tbl[9] = '{n: 17, b: 7,  vmode: 1, rmode: 1, perms: 1, words: 17};

      rst = 1'b1;
      quiet_inputs();
`ifdef ABSORB_MODE_SEL_EN
      mode_sel = 1'b0;
`endif
      #1;
      check_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_release");
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++)
         run_msg(tbl[i].n, tbl[i].b, tbl[i].vmode, tbl[i].rmode, tbl[i].perms, tbl[i].words);

      reset_mid_absorb();
      run_msg(3, 5, 0, 0, 1, 17);

      for (int i = 0; i < 8; i++) begin
         n = $urandom_range(1, 40);
         b = $urandom_range(0, 10);
         t = model_total(n, b, blk_len);
         run_msg(n, b, $urandom_range(0, 1), $urandom_range(0, 2), t / blk_len, t);
      end

`ifdef ABSORB_MODE_SEL_EN
      mode_sel = 1'b1;
      blk_len  = 21;
      run_msg(21, 3, 0, 0, 1, 21);
      run_msg(21, 8, 0, 1, 2, 42);
      mode_sel = 1'b0;
      blk_len  = 17;
      run_msg(17, 3, 0, 0, 1, 17);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
